// File: rtl/spi_thermometer_responder_if.sv
// SPI pin bundle between a mode-0 master and the thermometer responder.
// The master drives clock, select and SI; the responder drives SO and its output enable.
interface spi_thermometer_responder_if;
  logic spi_clk;
  logic spi_cs_n;
  logic spi_si;
  logic spi_so;
  logic spi_so_en;

  modport master (
    output spi_clk,
    output spi_cs_n,
    output spi_si,
    input  spi_so,
    input  spi_so_en
  );

  modport slave (
    input  spi_clk,
    input  spi_cs_n,
    input  spi_si,
    output spi_so,
    output spi_so_en
  );
endinterface

// File: rtl/spi_thermometer_responder.sv
// SPI mode-0 responder emulating the thermostat temperature sensor.
// Oversamples the SPI pins, decodes an 8-bit command and returns a 16-bit frame.
module spi_thermometer_responder #(
  parameter logic [7:0]  p_read_cmd  = 8'h50,
  parameter logic [7:0]  p_id_cmd    = 8'h4F,
  parameter logic [15:0] p_device_id = 16'h0A5A
) (
  input  logic                        i_clk,
  input  logic                        i_reset_n,
  input  logic [9:0]                  i_temperature,
  spi_thermometer_responder_if.slave  spi,
  output logic                        o_xfer_done,
  output logic                        o_cmd_err
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StCmd  = 2'd1;
  localparam logic [1:0] StData = 2'd2;
  localparam logic [1:0] StDone = 2'd3;

  // [0],[1] form the synchroniser, [2] is the delayed copy for edge detection.
  logic [2:0] sclk_q;
  logic [2:0] cs_q;
  logic [2:0] si_q;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      sclk_q <= 3'b000;
      cs_q   <= 3'b111;
      si_q   <= 3'b000;
    end else begin
      sclk_q <= {sclk_q[1:0], spi.spi_clk};
      cs_q   <= {cs_q[1:0], spi.spi_cs_n};
      si_q   <= {si_q[1:0], spi.spi_si};
    end
  end

  logic sclk_rise;
  logic sclk_fall;
  logic cs_rise;
  logic cs_fall;
  logic si_s;

  assign sclk_rise = sclk_q[1] & ~sclk_q[2];
  assign sclk_fall = ~sclk_q[1] & sclk_q[2];
  assign cs_rise   = cs_q[1] & ~cs_q[2];
  assign cs_fall   = ~cs_q[1] & cs_q[2];
  assign si_s      = si_q[1];

  logic [1:0]  state_q, state_d;
  logic [4:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  cmd_sr_q, cmd_sr_d;
  logic [15:0] tx_sr_q, tx_sr_d;
  logic [9:0]  temp_hold_q, temp_hold_d;
  logic        cmd_valid_q, cmd_valid_d;
  logic        so_q, so_d;
  logic        so_en_q, so_en_d;
  logic        xfer_done_q, xfer_done_d;
  logic        cmd_err_q, cmd_err_d;
  logic [7:0]  cmd_next;

  assign cmd_next = {cmd_sr_q[6:0], si_s};

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    cmd_sr_d    = cmd_sr_q;
    tx_sr_d     = tx_sr_q;
    temp_hold_d = temp_hold_q;
    cmd_valid_d = cmd_valid_q;
    so_d        = so_q;
    so_en_d     = so_en_q;
    xfer_done_d = 1'b0;
    cmd_err_d   = 1'b0;

    case (state_q)
      StIdle: begin
        so_d    = 1'b0;
        so_en_d = 1'b0;
        if (cs_fall) begin
          state_d     = StCmd;
          bit_cnt_d   = 5'd0;
          cmd_sr_d    = 8'h00;
          tx_sr_d     = 16'h0000;
          cmd_valid_d = 1'b0;
          temp_hold_d = i_temperature;
          so_en_d     = 1'b1;
        end
      end

      StCmd: begin
        // A select release outranks any SCLK edge seen in the same cycle.
        if (cs_rise) begin
          state_d = StIdle;
          so_d    = 1'b0;
          so_en_d = 1'b0;
        end else if (sclk_rise) begin
          cmd_sr_d  = cmd_next;
          bit_cnt_d = bit_cnt_q + 5'd1;
          if (bit_cnt_q == 5'd7) begin
            state_d   = StData;
            bit_cnt_d = 5'd0;
            if (cmd_next == p_read_cmd) begin
              tx_sr_d     = {temp_hold_q, 6'b000000};
              cmd_valid_d = 1'b1;
            end else if (cmd_next == p_id_cmd) begin
              tx_sr_d     = p_device_id;
              cmd_valid_d = 1'b1;
            end else begin
              tx_sr_d     = 16'h0000;
              cmd_valid_d = 1'b0;
              cmd_err_d   = 1'b1;
            end
          end
        end
      end

      StData: begin
        if (cs_rise) begin
          state_d = StIdle;
          so_d    = 1'b0;
          so_en_d = 1'b0;
        end else if (sclk_fall) begin
          so_d    = tx_sr_q[15];
          tx_sr_d = {tx_sr_q[14:0], 1'b0};
        end else if (sclk_rise) begin
          bit_cnt_d = bit_cnt_q + 5'd1;
          if (bit_cnt_q == 5'd15) begin
            state_d = StDone;
          end
        end
      end

      StDone: begin
        if (cs_rise) begin
          state_d     = StIdle;
          so_d        = 1'b0;
          so_en_d     = 1'b0;
          xfer_done_d = cmd_valid_q;
        end else if (sclk_fall) begin
          so_d = 1'b0;
        end
      end

      default: begin
        state_d = StIdle;
        so_d    = 1'b0;
        so_en_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q     <= StIdle;
      bit_cnt_q   <= 5'd0;
      cmd_sr_q    <= 8'h00;
      tx_sr_q     <= 16'h0000;
      temp_hold_q <= 10'h000;
      cmd_valid_q <= 1'b0;
      so_q        <= 1'b0;
      so_en_q     <= 1'b0;
      xfer_done_q <= 1'b0;
      cmd_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      cmd_sr_q    <= cmd_sr_d;
      tx_sr_q     <= tx_sr_d;
      temp_hold_q <= temp_hold_d;
      cmd_valid_q <= cmd_valid_d;
      so_q        <= so_d;
      so_en_q     <= so_en_d;
      xfer_done_q <= xfer_done_d;
      cmd_err_q   <= cmd_err_d;
    end
  end

  assign spi.spi_so    = so_q;
  assign spi.spi_so_en = so_en_q;
  assign o_xfer_done   = xfer_done_q;
  assign o_cmd_err     = cmd_err_q;

endmodule

// File: tb/tb_spi_thermometer_responder.sv
// Directed bench for spi_thermometer_responder: a mode-0 master model with
// expected frames queued at stimulus time and compared on reception.
module tb_spi_thermometer_responder;

  logic       r_clk = 1'b0;
  logic       reset_n;
  logic [9:0] temperature;
  logic       xfer_done;
  logic       cmd_err;

  always #5 r_clk = ~r_clk;

  spi_thermometer_responder_if spi_bus ();

  spi_thermometer_responder dut (
    .i_clk         (r_clk),
    .i_reset_n     (reset_n),
    .i_temperature (temperature),
    .spi           (spi_bus),
    .o_xfer_done   (xfer_done),
    .o_cmd_err     (cmd_err)
  );

  int          vectors     = 0;
  int          miscompares = 0;
  int          done_cnt    = 0;
  int          err_cnt     = 0;
  logic [31:0] rx_bits;
  logic [15:0] exp_q[$];

  always @(negedge r_clk) begin
    if (xfer_done === 1'b1) done_cnt++;
    if (cmd_err === 1'b1) err_cnt++;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge r_clk);
  endtask

  task automatic cs_low();
    rx_bits = '1;
    @(negedge r_clk);
    spi_bus.spi_cs_n = 1'b0;
    wait_clk(8);
  endtask

  task automatic cs_high();
    wait_clk(8);
    spi_bus.spi_cs_n = 1'b1;
    wait_clk(10);
  endtask

  // SI changes after SCLK falls; SO is sampled just before each rising edge.
  task automatic clock_bits(input logic [7:0] cmd, input int first, input int last);
    logic [2:0] idx;
    for (int i = first; i <= last; i++) begin
      idx = 3'(7 - i);
      spi_bus.spi_si = (i < 8) ? cmd[idx] : 1'b0;
      wait_clk(8);
      rx_bits[5'(i)] = spi_bus.spi_so;
      spi_bus.spi_clk = 1'b1;
      wait_clk(8);
      spi_bus.spi_clk = 1'b0;
    end
  endtask

  function automatic logic [15:0] frame_of();
    logic [15:0] f;
    for (int k = 0; k < 16; k++) f[4'(15 - k)] = rx_bits[5'(8 + k)];
    return f;
  endfunction

  task automatic run_frame(input string tag, input logic [7:0] cmd, input int nclk,
                           input logic [15:0] exp);
    exp_q.push_back(exp);
    cs_low();
    clock_bits(cmd, 0, nclk - 1);
    cs_high();
    check(tag, {16'h0, frame_of()}, {16'h0, exp_q.pop_front()});
  endtask

  int   d0;
  int   e0;
  logic en_seen;

  initial begin
    reset_n          = 1'b0;
    temperature      = 10'h05A;
    spi_bus.spi_clk  = 1'b0;
    spi_bus.spi_cs_n = 1'b1;
    spi_bus.spi_si   = 1'b0;
    wait_clk(3);
    check("reset_so", {31'h0, spi_bus.spi_so}, 32'h0);
    check("reset_so_en", {31'h0, spi_bus.spi_so_en}, 32'h0);
    check("reset_done", {31'h0, xfer_done}, 32'h0);
    check("reset_err", {31'h0, cmd_err}, 32'h0);
    reset_n = 1'b1;
    wait_clk(5);

    // Temperature read
    d0 = done_cnt; e0 = err_cnt;
    run_frame("read_05a", 8'h50, 24, 16'h1680);
    check("read_done_cnt", done_cnt - d0, 1);
    check("read_err_cnt", err_cnt - e0, 0);

    // Device ID and unknown command
    d0 = done_cnt;
    run_frame("id_frame", 8'h4F, 24, 16'h0A5A);
    check("id_done_cnt", done_cnt - d0, 1);

    d0 = done_cnt; e0 = err_cnt;
    exp_q.push_back(16'h0000);
    cs_low();
    clock_bits(8'h33, 0, 7);
    wait_clk(6);
    check("bad_err_after_8th", err_cnt - e0, 1);
    clock_bits(8'h33, 8, 23);
    cs_high();
    check("bad_frame", {16'h0, frame_of()}, {16'h0, exp_q.pop_front()});
    check("bad_err_cnt", err_cnt - e0, 1);
    check("bad_done_cnt", done_cnt - d0, 0);

    // Temperature held for the whole frame
    exp_q.push_back(16'h1680);
    cs_low();
    temperature = 10'h066;
    clock_bits(8'h50, 0, 23);
    cs_high();
    check("coherent_frame", {16'h0, frame_of()}, {16'h0, exp_q.pop_front()});
    run_frame("next_frame_066", 8'h50, 24, 16'h1980);

    // Abort after 12 clocks
    d0 = done_cnt; e0 = err_cnt;
    cs_low();
    clock_bits(8'h50, 0, 11);
    @(negedge r_clk);
    spi_bus.spi_cs_n = 1'b1;
    repeat (3) @(posedge r_clk);
    #1;
    check("abort_so_en", {31'h0, spi_bus.spi_so_en}, 32'h0);
    wait_clk(10);
    check("abort_done_cnt", done_cnt - d0, 0);
    check("abort_err_cnt", err_cnt - e0, 0);
    run_frame("after_abort", 8'h50, 24, 16'h1980);

    // Overlong frame: trailing bits read as zero
    d0 = done_cnt;
    run_frame("long_frame", 8'h50, 30, 16'h1980);
    check("long_tail_bits", {26'h0, rx_bits[29:24]}, 32'h0);
    check("long_done_cnt", done_cnt - d0, 1);

    // SCLK toggling while deselected
    d0 = done_cnt; e0 = err_cnt;
    en_seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      spi_bus.spi_si = i[0];
      for (int j = 0; j < 16; j++) begin
        if (j == 8) spi_bus.spi_clk = 1'b1;
        wait_clk(1);
        en_seen = en_seen | spi_bus.spi_so_en;
      end
      spi_bus.spi_clk = 1'b0;
    end
    wait_clk(10);
    check("idle_so_en", {31'h0, en_seen}, 32'h0);
    check("idle_done_cnt", done_cnt - d0, 0);
    check("idle_err_cnt", err_cnt - e0, 0);

    // Reset in the middle of the data phase
    temperature = 10'h05A;
    cs_low();
    clock_bits(8'h50, 0, 11);
    @(negedge r_clk);
    reset_n = 1'b0;
    #1;
    check("midreset_so_en", {31'h0, spi_bus.spi_so_en}, 32'h0);
    check("midreset_so", {31'h0, spi_bus.spi_so}, 32'h0);
    check("midreset_done", {31'h0, xfer_done}, 32'h0);
    check("midreset_err", {31'h0, cmd_err}, 32'h0);
    wait_clk(2);
    spi_bus.spi_cs_n = 1'b1;
    wait_clk(4);
    reset_n = 1'b1;
    wait_clk(4);
    temperature = 10'h3FF;
    d0 = done_cnt;
    run_frame("post_reset_3ff", 8'h50, 24, 16'hFFC0);
    check("post_reset_done_cnt", done_cnt - d0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
